// File: rtl/decoder_scan_reg_pkg.sv
// Package: decoder_pkg
// Shared types and helpers for the registered one-hot decoder with SCAN mode.
//   state_t     - controller states (IDLE, HOLD, SCAN)
//   MODE_*      - encodings of the mode input
//   next_index  - index advance with wrap-around at num_out-1
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SCAN
    } state_t;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Next channel in a SCAN walk; the last existing line wraps back to 0.
    function automatic int unsigned next_index(input int unsigned cur,
                                               input int unsigned num_out);
        return (cur >= num_out - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/decoder_scan_reg_if.sv
// Interface: decoder_scan_reg_if
// Groups the load request and decoded-output signals of decoder_scan_reg.
//   en, in_valid, mode, sel  - requester -> decoder
//   y, out_valid, idx, err, wrap - decoder -> requester
// Modports: master (requester side), slave (decoder side).
interface decoder_scan_reg_if #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned NUM_OUT = 8
);
    logic               en;
    logic               in_valid;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [NUM_OUT-1:0] y;
    logic               out_valid;
    logic [SEL_W-1:0]   idx;
    logic               err;
    logic               wrap;

    modport master (
        output en, in_valid, mode, sel,
        input  y, out_valid, idx, err, wrap
    );

    modport slave (
        input  en, in_valid, mode, sel,
        output y, out_valid, idx, err, wrap
    );
endinterface

// File: rtl/decoder_scan_reg_dec_onehot.sv
// Module: dec_onehot
// Purely combinational index to one-hot decoder.
//   idx      in   SEL_W    index to decode
//   onehot   out  NUM_OUT  active-high one-hot (all zero if idx out of range)
//   in_range out  1        idx < NUM_OUT
module dec_onehot #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned NUM_OUT = 8
) (
    input  logic [SEL_W-1:0]   idx,
    output logic [NUM_OUT-1:0] onehot,
    output logic               in_range
);

    always_comb begin
        onehot   = '0;
        in_range = (32'(idx) < NUM_OUT);
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            onehot[i] = (32'(idx) == i);
        end
    end

endmodule

// File: rtl/decoder_scan_reg.sv
// Module: decoder_scan_reg
// Registered N-to-M one-hot decoder with a SCAN mode that walks the active
// line through all channels with wrap-around.
//   clk  in  clock, rising edge
//   rst  in  synchronous reset, active-high
//   bus  slave modport of decoder_scan_reg_if:
//        en, in_valid, mode, sel in; y, out_valid, idx, err, wrap out
// All outputs are registered (one cycle latency, no input-to-output path).
module decoder_scan_reg
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned NUM_OUT    = 8,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input logic               clk,
    input logic               rst,
    decoder_scan_reg_if.slave bus
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] hot_q, hot_d;    // active-high line image
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               wrap_q, wrap_d;

    logic [SEL_W-1:0]   dec_idx;
    logic [NUM_OUT-1:0] dec_hot;
    logic               dec_in_range;
    logic [SEL_W-1:0]   step_idx;

    // One decoder is shared between the load path and the SCAN step; the
    // controller chooses which index it sees.
    dec_onehot #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .idx      (dec_idx),
        .onehot   (dec_hot),
        .in_range (dec_in_range)
    );

    assign step_idx = SEL_W'(next_index(32'(idx_q), NUM_OUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hot_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hot_q   <= hot_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hot_d   = hot_q;
        valid_d = valid_q;
        err_d   = err_q;
        wrap_d  = 1'b0;
        dec_idx = idx_q;

        if (bus.in_valid) begin
            // A load always wins, including over a pending SCAN step.
            dec_idx = bus.sel;
            if (dec_in_range) begin
                state_d = (bus.mode == MODE_SCAN) ? SCAN : HOLD;
                idx_d   = bus.sel;
                hot_d   = dec_hot;
                valid_d = 1'b1;
                err_d   = 1'b0;
            end else begin
                state_d = IDLE;
                idx_d   = '0;
                hot_d   = '0;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
        end else begin
            unique case (state_q)
                SCAN: begin
                    if (bus.en) begin
                        dec_idx = step_idx;
                        idx_d   = step_idx;
                        hot_d   = dec_hot;
                        wrap_d  = (32'(idx_q) == NUM_OUT - 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.y         = ACTIVE_LOW ? ~hot_q : hot_q;
    assign bus.out_valid = valid_q;
    assign bus.idx       = idx_q;
    assign bus.err       = err_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan_reg.sv
// Testbench: two decoder instances (8 lines active-high, 6 lines active-low)
// share one stimulus stream; expected outputs come from a behavioural model
// and are compared by a separate monitor through per-instance queues.
module tb_decoder_scan_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoder_scan_reg_if #(.SEL_W(3), .NUM_OUT(8)) bus_a ();
    decoder_scan_reg_if #(.SEL_W(3), .NUM_OUT(6)) bus_b ();

    decoder_scan_reg #(.SEL_W(3), .NUM_OUT(8), .ACTIVE_LOW(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    decoder_scan_reg #(.SEL_W(3), .NUM_OUT(6), .ACTIVE_LOW(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        int y;
        int v;
        int idx;
        int e;
        int w;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: which line is lit (if any), whether it is walking, last error.
    int m_lit[2];
    bit m_act[2];
    bit m_walk[2];
    bit m_err[2];
    int nout[2] = '{8, 6};
    bit alow[2] = '{1'b0, 1'b1};

    function automatic exp_t predict(input int d, input bit r, input bit e,
                                     input bit v, input bit m, input int s);
        exp_t x;
        int   pat;
        bit   w = 1'b0;
        if (r) begin
            m_lit[d] = 0; m_act[d] = 0; m_walk[d] = 0; m_err[d] = 0;
        end else if (v) begin
            if (s < nout[d]) begin
                m_lit[d] = s; m_act[d] = 1; m_walk[d] = m; m_err[d] = 0;
            end else begin
                m_lit[d] = 0; m_act[d] = 0; m_walk[d] = 0; m_err[d] = 1;
            end
        end else if (m_act[d] && m_walk[d] && e) begin
            w = (m_lit[d] == nout[d] - 1);
            m_lit[d] = (m_lit[d] + 1) % nout[d];
        end
        pat = m_act[d] ? (1 << m_lit[d]) : 0;
        if (alow[d]) pat = ~pat;
        pat = pat & ((1 << nout[d]) - 1);
        x.y = pat; x.v = m_act[d]; x.idx = m_lit[d]; x.e = m_err[d]; x.w = w;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        end
    endtask

    // Drive one cycle of stimulus away from the edge and queue the response
    // expected after the next rising edge.
    task automatic cyc(input bit r, input bit e, input bit v, input bit m, input int s);
        @(posedge clk);
        #3;
        rst = r;
        bus_a.en = e; bus_a.in_valid = v; bus_a.mode = m; bus_a.sel = 3'(s);
        bus_b.en = e; bus_b.in_valid = v; bus_b.mode = m; bus_b.sel = 3'(s);
        q_a.push_back(predict(0, r, e, v, m, s));
        q_b.push_back(predict(1, r, e, v, m, s));
    endtask

    // Monitor: outputs are registered, so each cycle presents one response.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                x = q_a.pop_front();
                chk("a_y",    int'(bus_a.y),         x.y);
                chk("a_val",  int'(bus_a.out_valid), x.v);
                chk("a_idx",  int'(bus_a.idx),       x.idx);
                chk("a_err",  int'(bus_a.err),       x.e);
                chk("a_wrap", int'(bus_a.wrap),      x.w);
            end
            if (q_b.size() > 0) begin
                x = q_b.pop_front();
                chk("b_y",    int'(bus_b.y),         x.y);
                chk("b_val",  int'(bus_b.out_valid), x.v);
                chk("b_idx",  int'(bus_b.idx),       x.idx);
                chk("b_err",  int'(bus_b.err),       x.e);
                chk("b_wrap", int'(bus_b.wrap),      x.w);
            end
        end
    end

    initial begin
        int guard;
        bus_a.en = 0; bus_a.in_valid = 0; bus_a.mode = 0; bus_a.sel = '0;
        bus_b.en = 0; bus_b.in_valid = 0; bus_b.mode = 0; bus_b.sel = '0;

        // Reset defaults
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // DECODE hold, then en/sel/mode toggling without load
        cyc(0, 0, 1, 0, 5);
        cyc(0, 1, 0, 1, 2);
        cyc(0, 0, 0, 0, 7);
        cyc(0, 1, 0, 1, 1);
        // SCAN wrap from 6 (out of range on the 6-line instance)
        cyc(0, 1, 1, 1, 6);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        // Freeze, then load priority over a step
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 4);
        cyc(0, 1, 0, 0, 0);
        // Out of range, error sticky until a good load
        cyc(0, 1, 1, 0, 7);
        cyc(0, 1, 0, 1, 3);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 3);
        // Scan on both at idx 5 (wrap on 6-line), then reset mid-scan
        cyc(0, 1, 1, 1, 5);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 7);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);

        // Randomised phase
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)));
        end
        cyc(0, 0, 0, 0, 0);

        guard = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        n_cmp++;
        if (q_a.size() > 0 || q_b.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d responses left, required 0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
